riscv_ram_1r1w_generic: RTL and testbench
=========================================

RISCV_RAM_1R1W_GENERIC -- requirements
Module: riscv_ram_1r1w_generic

Interface
REQ-001 SHALL have parameter ABITS, default 10, address width; depth = 2**ABITS words.
REQ-002 SHALL have parameter DBITS, default 32, data width; any value >= 1.
REQ-003 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding, 0 = read-old-data.
REQ-004 SHALL have parameter OUT_REG, default 0; 1 = extra output pipeline stage.
REQ-005 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port waddr_i  input  ABITS  write address.
REQ-008 SHALL have port we_i  input  1  write enable.
REQ-009 SHALL have port be_i  input  (DBITS+7)/8  byte enables; bit k covers din_i[8k+7:8k], top lane truncated at DBITS-1.
REQ-010 SHALL have port din_i  input  DBITS  write data.
REQ-011 SHALL have port raddr_i  input  ABITS  read address.
REQ-012 SHALL have port re_i  input  1  read request.
REQ-013 SHALL have port dout_o  output  DBITS  read data.
REQ-014 SHALL have port dout_valid_o  output  1  one-cycle pulse marking new dout_o.

Function
REQ-015 SHALL write lane k of mem[waddr_i] at clock edge when we_i=1, be_i[k]=1, rst_ni=1; other lanes unchanged.
REQ-016 SHALL capture a read when re_i=1; latency 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from request edge to dout_o/dout_valid_o.
REQ-017 SHALL hold dout_o unchanged when no read completes; dout_valid_o=0 in those cycles.
REQ-018 SHALL accept back-to-back reads every cycle, full throughput, results in request order.
REQ-019 BYPASS=1, same-cycle we_i=1, re_i=1, waddr_i==raddr_i: returned word SHALL be enabled lanes from din_i, disabled lanes from prior mem contents.
REQ-020 BYPASS=0, same collision: returned word SHALL be prior mem contents (read-before-write).
REQ-021 Collision with be_i all-zero SHALL return prior contents in either mode.
REQ-022 SHALL support addresses 0 and 2**ABITS-1 with no wrap or aliasing; no out-of-range addresses exist.
REQ-023 Memory contents SHALL be undefined before first write; no initialisation.

Reset
REQ-024 rst_ni=0 SHALL asynchronously force dout_o=0, dout_valid_o=0 and clear all pipeline/valid registers.
REQ-025 Reads in flight at reset assertion SHALL be discarded; no dout_valid_o pulse after reset release for them.
REQ-026 Writes SHALL be ignored while rst_ni=0; memory array itself SHALL not be reset (contents preserved).
REQ-027 First read requested in cycle after rst_ni deasserts SHALL complete normally.

Structure
REQ-028 Byte-lane count (DBITS+7)/8 SHALL be a local constant; no shared package entries required.
REQ-029 Memory array SHALL be a plain inferrable register array without reset; BYPASS merge and OUT_REG stage in separate registered logic.
REQ-030 No sub-module required; lane merge SHALL be a local function used by write path and bypass path.

Verification
REQ-031 Write 0xDEADBEEF to addr 5 (be=0xF), read addr 5 next cycle -> dout_o=0xDEADBEEF with dout_valid_o pulse 1 cycle (OUT_REG=0) / 2 cycles (OUT_REG=1) after re_i.
REQ-032 mem[3]=0x11223344; write 0xAABBCCDD be=0x5 -> read returns 0x11BB33DD.
REQ-033 mem[7]=0x00000000; same-cycle write 0xCAFEF00D be=0x3 and read addr 7 -> BYPASS=1 returns 0x0000F00D, BYPASS=0 returns 0x00000000.
REQ-034 Reads addr 0,1,2,1023 on 4 consecutive cycles after preload -> 4 consecutive valid pulses, data in order, addr 1023 correct.
REQ-035 Issue read, assert rst_ni=0 before completion -> dout_o=0, no valid pulse; mem preserved, re-read after release returns stored value.
REQ-036 DBITS=20: write 0xFFFFF be=0x4 to zeroed word -> read returns 0xF0000.

Source files
------------

// File: rtl/riscv_ram_1r1w_generic_pkg.sv
// Shared constants for the generic one-read/one-write RAM.
package riscv_ram_1r1w_generic_pkg;

  localparam int unsigned LANE_BITS = 32'd8;

endpackage

// File: rtl/riscv_ram_1r1w_generic.sv
// One-read/one-write synchronous RAM with byte-lane writes, optional
// write-to-read forwarding on address collision and an optional output stage.
module riscv_ram_1r1w_generic
  import riscv_ram_1r1w_generic_pkg::*;
#(
  parameter int ABITS   = 10,
  parameter int DBITS   = 32,
  parameter int BYPASS  = 1,
  parameter int OUT_REG = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [ABITS-1:0]             waddr_i,
  input  logic                         we_i,
  input  logic [(DBITS+7)/8-1:0]       be_i,
  input  logic [DBITS-1:0]             din_i,
  input  logic [ABITS-1:0]             raddr_i,
  input  logic                         re_i,
  output logic [DBITS-1:0]             dout_o,
  output logic                         dout_valid_o
);

  localparam int NUM_LANES = (DBITS + LANE_BITS - 32'd1) / LANE_BITS;
  localparam int DEPTH     = 2 ** ABITS;

  logic [DBITS-1:0] mem_r [DEPTH];
  logic [DBITS-1:0] rd_word_s;
  logic [DBITS-1:0] rd_data_r;
  logic             rd_valid_r;

  // Bits of lanes enabled in lane_en come from new_word, the rest from old_word.
  function automatic logic [DBITS-1:0] lane_merge(
    input logic [DBITS-1:0]     old_word,
    input logic [DBITS-1:0]     new_word,
    input logic [NUM_LANES-1:0] lane_en
  );
    logic [DBITS-1:0] merged;
    for (int i = 0; i < DBITS; i++) begin
      merged[i] = lane_en[i / LANE_BITS] ? new_word[i] : old_word[i];
    end
    return merged;
  endfunction

  // Storage array: no reset so it maps onto plain RAM; writes are blocked during reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && we_i) begin
      mem_r[waddr_i] <= lane_merge(mem_r[waddr_i], din_i, be_i);
    end
  end

  // Read word selection: forward the in-flight write on a collision when enabled.
  always_comb begin
    rd_word_s = mem_r[raddr_i];
    if ((BYPASS != 32'sd0) && we_i && (waddr_i == raddr_i)) begin
      rd_word_s = lane_merge(mem_r[raddr_i], din_i, be_i);
    end else begin
      rd_word_s = mem_r[raddr_i];
    end
  end

  // First read stage: data only moves on a request so the output holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= re_i;
      if (re_i) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  if (OUT_REG != 32'sd0) begin : g_out_reg
    logic [DBITS-1:0] out_data_r;
    logic             out_valid_r;

    // Second read stage, advancing only when the first stage holds a completed read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_data_r  <= '0;
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= rd_valid_r;
        if (rd_valid_r) begin
          out_data_r <= rd_data_r;
        end
      end
    end

    assign dout_o       = out_data_r;
    assign dout_valid_o = out_valid_r;
  end else begin : g_no_out_reg
    assign dout_o       = rd_data_r;
    assign dout_valid_o = rd_valid_r;
  end

endmodule

// File: tb/tb_riscv_ram_1r1w_generic.sv
// Self-checking bench: three RAM configurations checked against a behavioural array model.
module tb_riscv_ram_1r1w_generic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  waddr, raddr;
  logic        we, re;
  logic [3:0]  be;
  logic [31:0] din;
  logic [31:0] dout_a, dout_b;
  logic        val_a, val_b;

  logic [3:0]  c_waddr, c_raddr;
  logic        c_we, c_re;
  logic [2:0]  c_be;
  logic [19:0] c_din, c_dout;
  logic        c_val;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] model_mem [1024];
  logic [19:0] model_c [16];

  always #5 clk = ~clk;

  riscv_ram_1r1w_generic #(.ABITS(10), .DBITS(32), .BYPASS(1), .OUT_REG(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .we_i(we), .be_i(be), .din_i(din),
    .raddr_i(raddr), .re_i(re), .dout_o(dout_a), .dout_valid_o(val_a));

  riscv_ram_1r1w_generic #(.ABITS(10), .DBITS(32), .BYPASS(0), .OUT_REG(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .we_i(we), .be_i(be), .din_i(din),
    .raddr_i(raddr), .re_i(re), .dout_o(dout_b), .dout_valid_o(val_b));

  riscv_ram_1r1w_generic #(.ABITS(4), .DBITS(20), .BYPASS(1), .OUT_REG(0)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .waddr_i(c_waddr), .we_i(c_we), .be_i(c_be), .din_i(c_din),
    .raddr_i(c_raddr), .re_i(c_re), .dout_o(c_dout), .dout_valid_o(c_val));

  function automatic logic [31:0] merge32(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] en);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (en[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  function automatic logic [19:0] merge20(input logic [19:0] old_w, input logic [19:0] new_w,
                                          input logic [2:0] en);
    logic [19:0] r;
    r = old_w;
    if (en[0]) r[7:0]   = new_w[7:0];
    if (en[1]) r[15:8]  = new_w[15:8];
    if (en[2]) r[19:16] = new_w[19:16];
    return r;
  endfunction

  task automatic step(input logic w, input logic [9:0] wa, input logic [3:0] wbe,
                      input logic [31:0] wd, input logic r, input logic [9:0] ra);
    we = w; waddr = wa; be = wbe; din = wd; re = r; raddr = ra;
    @(posedge clk);
    if (rst_n && w) model_mem[wa] = merge32(model_mem[wa], wd, wbe);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic step_c(input logic w, input logic [3:0] wa, input logic [2:0] wbe,
                        input logic [19:0] wd, input logic r, input logic [3:0] ra);
    c_we = w; c_waddr = wa; c_be = wbe; c_din = wd; c_re = r; c_raddr = ra;
    @(posedge clk);
    if (rst_n && w) model_c[wa] = merge20(model_c[wa], wd, wbe);
    #1;
    c_we = 1'b0; c_re = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    total_cnt++; if ({val_a, dout_a} !== 33'd0) $display("FAIL reset_a got=%h exp=0", {val_a, dout_a}); else pass_cnt++;
    total_cnt++; if ({val_b, dout_b} !== 33'd0) $display("FAIL reset_b got=%h exp=0", {val_b, dout_b}); else pass_cnt++;
    total_cnt++; if ({c_val, c_dout} !== 21'd0) $display("FAIL reset_c got=%h exp=0", {c_val, c_dout}); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    step(1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0, 10'd0);
    step(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd5);
    total_cnt++; if ({val_a, dout_a} !== {1'b1, 32'hDEADBEEF}) $display("FAIL wr_a_lat1 got=%h exp=%h", {val_a, dout_a}, {1'b1, 32'hDEADBEEF}); else pass_cnt++;
    total_cnt++; if (val_b !== 1'b0) $display("FAIL wr_b_early got=%b exp=0", val_b); else pass_cnt++;
    step(1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 10'd0);
    total_cnt++; if ({val_a, dout_a} !== {1'b0, 32'hDEADBEEF}) $display("FAIL wr_a_hold got=%h exp=%h", {val_a, dout_a}, {1'b0, 32'hDEADBEEF}); else pass_cnt++;
    total_cnt++; if ({val_b, dout_b} !== {1'b1, 32'hDEADBEEF}) $display("FAIL wr_b_lat2 got=%h exp=%h", {val_b, dout_b}, {1'b1, 32'hDEADBEEF}); else pass_cnt++;
    step(1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 10'd0);
    total_cnt++; if ({val_b, dout_b} !== {1'b0, 32'hDEADBEEF}) $display("FAIL wr_b_hold got=%h exp=%h", {val_b, dout_b}, {1'b0, 32'hDEADBEEF}); else pass_cnt++;
  endtask

  task automatic test_byte_enable;
    step(1'b1, 10'd3, 4'hF, 32'h11223344, 1'b0, 10'd0);
    step(1'b1, 10'd3, 4'h5, 32'hAABBCCDD, 1'b0, 10'd0);
    step(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd3);
    total_cnt++; if ({val_a, dout_a} !== {1'b1, 32'h11BB33DD}) $display("FAIL be_a got=%h exp=%h", {val_a, dout_a}, {1'b1, 32'h11BB33DD}); else pass_cnt++;
    step(1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 10'd0);
    total_cnt++; if ({val_b, dout_b} !== {1'b1, 32'h11BB33DD}) $display("FAIL be_b got=%h exp=%h", {val_b, dout_b}, {1'b1, 32'h11BB33DD}); else pass_cnt++;
  endtask

  task automatic test_collision;
    step(1'b1, 10'd7, 4'hF, 32'h00000000, 1'b0, 10'd0);
    step(1'b1, 10'd7, 4'h3, 32'hCAFEF00D, 1'b1, 10'd7);
    total_cnt++; if ({val_a, dout_a} !== {1'b1, 32'h0000F00D}) $display("FAIL coll_bypass got=%h exp=%h", {val_a, dout_a}, {1'b1, 32'h0000F00D}); else pass_cnt++;
    step(1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 10'd0);
    total_cnt++; if ({val_b, dout_b} !== {1'b1, 32'h00000000}) $display("FAIL coll_old got=%h exp=%h", {val_b, dout_b}, {1'b1, 32'h00000000}); else pass_cnt++;
    step(1'b1, 10'd7, 4'h0, 32'hFFFFFFFF, 1'b1, 10'd7);
    total_cnt++; if ({val_a, dout_a} !== {1'b1, 32'h0000F00D}) $display("FAIL coll_be0_a got=%h exp=%h", {val_a, dout_a}, {1'b1, 32'h0000F00D}); else pass_cnt++;
    step(1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 10'd0);
    total_cnt++; if ({val_b, dout_b} !== {1'b1, 32'h0000F00D}) $display("FAIL coll_be0_b got=%h exp=%h", {val_b, dout_b}, {1'b1, 32'h0000F00D}); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [9:0]  addrs [4];
    logic [31:0] vals [4];
    addrs[0] = 10'd0; addrs[1] = 10'd1; addrs[2] = 10'd2; addrs[3] = 10'd1023;
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      step(1'b1, addrs[i], 4'hF, vals[i], 1'b0, 10'd0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 10'd0, 4'h0, 32'h0, (i < 4), (i < 4) ? addrs[i] : 10'd0);
      if (i < 4) begin
        total_cnt++; if ({val_a, dout_a} !== {1'b1, vals[i]}) $display("FAIL b2b_a%0d got=%h exp=%h", i, {val_a, dout_a}, {1'b1, vals[i]}); else pass_cnt++;
      end else begin
        total_cnt++; if (val_a !== 1'b0) $display("FAIL b2b_a_idle%0d got=%b exp=0", i, val_a); else pass_cnt++;
      end
      if (i >= 1 && i <= 4) begin
        total_cnt++; if ({val_b, dout_b} !== {1'b1, vals[i-1]}) $display("FAIL b2b_b%0d got=%h exp=%h", i, {val_b, dout_b}, {1'b1, vals[i-1]}); else pass_cnt++;
      end else begin
        total_cnt++; if (val_b !== 1'b0) $display("FAIL b2b_b_idle%0d got=%b exp=0", i, val_b); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_inflight;
    step(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd5);
    #2; rst_n = 1'b0; #1;
    total_cnt++; if ({val_a, dout_a} !== 33'd0) $display("FAIL rst_fl_a got=%h exp=0", {val_a, dout_a}); else pass_cnt++;
    total_cnt++; if ({val_b, dout_b} !== 33'd0) $display("FAIL rst_fl_b got=%h exp=0", {val_b, dout_b}); else pass_cnt++;
    we = 1'b1; waddr = 10'd5; be = 4'hF; din = 32'h0;
    @(posedge clk); #1;
    we = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd5);
    total_cnt++; if ({val_a, dout_a} !== {1'b1, 32'hDEADBEEF}) $display("FAIL rst_reread_a got=%h exp=%h", {val_a, dout_a}, {1'b1, 32'hDEADBEEF}); else pass_cnt++;
    total_cnt++; if ({val_b, dout_b} !== 33'd0) $display("FAIL rst_ghost_b got=%h exp=0", {val_b, dout_b}); else pass_cnt++;
    step(1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 10'd0);
    total_cnt++; if ({val_b, dout_b} !== {1'b1, 32'hDEADBEEF}) $display("FAIL rst_reread_b got=%h exp=%h", {val_b, dout_b}, {1'b1, 32'hDEADBEEF}); else pass_cnt++;
  endtask

  task automatic test_dbits20;
    logic [19:0] exp_c;
    step_c(1'b1, 4'd2, 3'h7, 20'h00000, 1'b0, 4'd0);
    step_c(1'b1, 4'd2, 3'h4, 20'hFFFFF, 1'b0, 4'd0);
    step_c(1'b0, 4'd0, 3'h0, 20'h0, 1'b1, 4'd2);
    total_cnt++; if ({c_val, c_dout} !== {1'b1, 20'hF0000}) $display("FAIL d20_lane2 got=%h exp=%h", {c_val, c_dout}, {1'b1, 20'hF0000}); else pass_cnt++;
    step_c(1'b1, 4'd15, 3'h7, 20'hABCDE, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  rbe;
      logic [19:0] rd;
      rbe = 3'($urandom_range(0, 7));
      rd  = 20'($urandom);
      exp_c = merge20(model_c[15], rd, rbe);
      step_c(1'b1, 4'd15, rbe, rd, 1'b1, 4'd15);
      total_cnt++; if ({c_val, c_dout} !== {1'b1, exp_c}) $display("FAIL d20_top%0d got=%h exp=%h", i, {c_val, c_dout}, {1'b1, exp_c}); else pass_cnt++;
    end
  endtask

  task automatic test_random;
    logic [31:0] hold_a, hold_b, pend_eb, old_w, ea;
    logic        known_a, known_b, pend_b;
    logic        w, r;
    logic [9:0]  wa, ra;
    logic [3:0]  wbe;
    logic [31:0] wd;
    int          sel;
    known_a = 1'b0; known_b = 1'b0; pend_b = 1'b0;
    hold_a = '0; hold_b = '0; pend_eb = '0;
    for (int i = 0; i < 8; i++) step(1'b1, 10'(i), 4'hF, $urandom, 1'b0, 10'd0);
    step(1'b1, 10'd1023, 4'hF, $urandom, 1'b0, 10'd0);
    for (int n = 0; n < 400; n++) begin
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 8); wa = (sel == 8) ? 10'd1023 : 10'(sel);
      sel = $urandom_range(0, 8); ra = (sel == 8) ? 10'd1023 : 10'(sel);
      wbe = 4'($urandom_range(0, 15));
      wd = $urandom;
      old_w = model_mem[ra];
      ea = (w && wa == ra) ? merge32(old_w, wd, wbe) : old_w;
      step(w, wa, wbe, wd, r, ra);
      if (r) begin
        total_cnt++; if ({val_a, dout_a} !== {1'b1, ea}) $display("FAIL rnd_a%0d got=%h exp=%h", n, {val_a, dout_a}, {1'b1, ea}); else pass_cnt++;
        hold_a = ea; known_a = 1'b1;
      end else if (known_a) begin
        total_cnt++; if ({val_a, dout_a} !== {1'b0, hold_a}) $display("FAIL rnd_a_hold%0d got=%h exp=%h", n, {val_a, dout_a}, {1'b0, hold_a}); else pass_cnt++;
      end
      if (pend_b) begin
        total_cnt++; if ({val_b, dout_b} !== {1'b1, pend_eb}) $display("FAIL rnd_b%0d got=%h exp=%h", n, {val_b, dout_b}, {1'b1, pend_eb}); else pass_cnt++;
        hold_b = pend_eb; known_b = 1'b1;
      end else if (known_b) begin
        total_cnt++; if ({val_b, dout_b} !== {1'b0, hold_b}) $display("FAIL rnd_b_hold%0d got=%h exp=%h", n, {val_b, dout_b}, {1'b0, hold_b}); else pass_cnt++;
      end
      pend_b = r; pend_eb = old_w;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; waddr = '0; raddr = '0; be = '0; din = '0;
    c_we = 1'b0; c_re = 1'b0; c_waddr = '0; c_raddr = '0; c_be = '0; c_din = '0;
    test_reset;
    test_write_read;
    test_byte_enable;
    test_collision;
    test_back_to_back;
    test_reset_inflight;
    test_dbits20;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
